la_capture_ctrl: RTL and testbench

LA_CAPTURE_CTRL -- requirements
Module: la_capture_ctrl

---
 rtl/la_pkg.sv | 44 ++++
 rtl/la_sample_tick.sv | 40 ++++
 rtl/la_capture_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_la_capture_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// ---------------------------------------------------------------------------
// la_pkg
// Shared definitions for the logic-analyser capture controller:
//   - trig_mode_e : trigger condition encodings seen on the trig_mode port
//   - la_state_e  : capture state machine encoding
//   - TRIG_MODE_W : width of the trig_mode command field
//   - trig_hit()  : evaluates one trigger condition for a single channel
// ---------------------------------------------------------------------------
package la_pkg;

  localparam int TRIG_MODE_W = 2;

  typedef enum logic [TRIG_MODE_W-1:0] {
    TRIG_RISE = 2'd0,
    TRIG_FALL = 2'd1,
    TRIG_HIGH = 2'd2,
    TRIG_LOW  = 2'd3
  } trig_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } la_state_e;

  // Edge modes need a valid previous sample; the first tick of a capture
  // has none, so edges can never fire there. Level modes only look at cur.
  function automatic logic trig_hit(trig_mode_e mode, logic prevValid,
                                    logic prev, logic cur);
    logic hit;
    hit = 1'b0;
    case (mode)
      TRIG_RISE: hit = prevValid && !prev && cur;
      TRIG_FALL: hit = prevValid && prev && !cur;
      TRIG_HIGH: hit = cur;
      TRIG_LOW:  hit = !cur;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/la_sample_tick.sv
// ---------------------------------------------------------------------------
// la_sample_tick
// Sample-period generator. While enabled it emits a one-cycle tick on the
// first enabled cycle and then every i_divide+1 cycles. Disabling it
// rearms it so the next enable ticks immediately.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_enable    : run the divider (capture in progress)
//   i_divide    : latched divide value, period = i_divide+1 clocks
//   o_tick      : sample tick
// ---------------------------------------------------------------------------
module la_sample_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic [DIV_W-1:0] i_divide,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_count;

  // Down-counter that reloads with the divide value after each tick and is
  // parked at zero while idle, so the first enabled cycle is a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!i_enable) begin
      r_count <= '0;
    end else if (r_count == '0) begin
      r_count <= i_divide;
    end else begin
      r_count <= r_count - DIV_W'(1);
    end
  end

  assign o_tick = i_enable && (r_count == '0);

endmodule

// File: rtl/la_capture_ctrl.sv
// ---------------------------------------------------------------------------
// la_capture_ctrl
// Logic-analyser capture controller. Samples the probe bus on divider ticks
// and streams samples into a circular capture memory through a req/ack
// write port: a pre-trigger window, then an armed phase that wraps until the
// trigger, then a post-trigger window that fills the rest of the memory.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   probe               : probe inputs (already synchronised)
//   divide, pos         : sample period - 1, pre-trigger fraction
//   trig_ch, trig_mode  : trigger channel and condition (la_pkg encodings)
//   start, abort        : one-cycle arm / cancel pulses
//   busy, done, overrun : status (done and overrun are sticky)
//   trig_addr           : memory address holding the trigger sample
//   wr_req/wr_addr/wr_data/wr_ack : capture memory write handshake
// ---------------------------------------------------------------------------
module la_capture_ctrl
  import la_pkg::*;
#(
  parameter int PROBE_W = 8,
  parameter int ADDR_W  = 17,
  parameter int DIV_W   = 8,
  parameter int POS_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PROBE_W-1:0]         probe,
  input  logic [DIV_W-1:0]           divide,
  input  logic [POS_W-1:0]           pos,
  input  logic [$clog2(PROBE_W)-1:0] trig_ch,
  input  logic [TRIG_MODE_W-1:0]     trig_mode,
  input  logic                       start,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun,
  output logic [ADDR_W-1:0]          trig_addr,
  output logic                       wr_req,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [PROBE_W-1:0]         wr_data,
  input  logic                       wr_ack
);

  localparam int              CH_W    = $clog2(PROBE_W);
  localparam int              SHIFT   = ADDR_W - POS_W;
  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  la_state_e            r_state, w_nextState;
  logic [DIV_W-1:0]     r_div;
  logic [POS_W-1:0]     r_pos;
  logic [CH_W-1:0]      r_ch;
  trig_mode_e           r_mode;
  logic                 r_prev, r_prevValid;
  logic [ADDR_W:0]      r_sampCnt;
  logic                 r_wrReq, r_overrun;
  logic [ADDR_W-1:0]    r_wrAddr, r_trigAddr;
  logic [PROBE_W-1:0]   r_wrData;

  logic                 w_tick, w_busy, w_cur, w_startOk;
  logic [ADDR_W:0]      w_preCount, w_postCount;
  logic                 w_armedLike, w_postFull, w_wantSample;
  logic                 w_drop, w_sample, w_trig, w_preLast;

  la_sample_tick #(.DIV_W(DIV_W)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (w_busy),
    .i_divide (r_div),
    .o_tick   (w_tick)
  );

  assign w_busy      = (r_state == ST_PRE) || (r_state == ST_ARMED) ||
                       (r_state == ST_POST);
  assign w_startOk   = start && !abort &&
                       ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_cur       = probe[r_ch];
  assign w_preCount  = {{(ADDR_W+1-POS_W){1'b0}}, r_pos} << SHIFT;
  assign w_postCount = DEPTH - w_preCount;

  // With no pre-trigger window the very first tick is already an armed tick.
  assign w_armedLike = (r_state == ST_ARMED) ||
                       ((r_state == ST_PRE) && (w_preCount == '0));
  // Once the post window is full, later ticks are simply not needed.
  assign w_postFull   = (r_state == ST_POST) && (r_sampCnt == w_postCount);
  assign w_wantSample = w_tick && !w_postFull;
  assign w_drop       = w_wantSample && r_wrReq;
  assign w_sample     = w_wantSample && !r_wrReq;
  assign w_trig       = w_sample && w_armedLike &&
                        trig_hit(r_mode, r_prevValid, r_prev, w_cur);
  assign w_preLast    = w_sample && (r_state == ST_PRE) &&
                        (w_preCount != '0) &&
                        ((r_sampCnt + CNT_ONE) == w_preCount);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; abort overrides everything else.
  always_comb begin
    w_nextState = r_state;
    if (abort) begin
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (start) w_nextState = ST_PRE;
        ST_PRE: begin
          if (w_trig) begin
            w_nextState = ST_POST;
          end else if (w_sample && ((w_preCount == '0) || w_preLast)) begin
            w_nextState = ST_ARMED;
          end
        end
        ST_ARMED: if (w_trig) w_nextState = ST_POST;
        ST_POST:  if (w_postFull && (!r_wrReq || wr_ack)) w_nextState = ST_DONE;
        default:  w_nextState = ST_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_PRE, ST_ARMED, ST_POST: busy = 1'b1;
      ST_DONE:                   done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: settings latch, sample capture, write handshake and counters.
  // A sample is only taken when no write is outstanding, so an address
  // increment on ack and a new capture never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div       <= '0;
      r_pos       <= '0;
      r_ch        <= '0;
      r_mode      <= TRIG_RISE;
      r_prev      <= 1'b0;
      r_prevValid <= 1'b0;
      r_sampCnt   <= '0;
      r_wrReq     <= 1'b0;
      r_overrun   <= 1'b0;
      r_wrAddr    <= '0;
      r_trigAddr  <= '0;
      r_wrData    <= '0;
    end else if (abort) begin
      r_wrReq <= 1'b0;
    end else if (w_startOk) begin
      r_div       <= divide;
      r_pos       <= pos;
      r_ch        <= trig_ch;
      r_mode      <= trig_mode_e'(trig_mode);
      r_prev      <= 1'b0;
      r_prevValid <= 1'b0;
      r_sampCnt   <= '0;
      r_wrReq     <= 1'b0;
      r_overrun   <= 1'b0;
      r_wrAddr    <= '0;
    end else begin
      if (r_wrReq && wr_ack) begin
        r_wrReq  <= 1'b0;
        r_wrAddr <= r_wrAddr + ADDR_W'(1);
      end
      if (w_tick) begin
        r_prev      <= w_cur;
        r_prevValid <= 1'b1;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
      if (w_sample) begin
        r_wrReq  <= 1'b1;
        r_wrData <= probe;
        if (w_trig) begin
          r_sampCnt  <= CNT_ONE;
          r_trigAddr <= r_wrAddr;
        end else if (r_state == ST_PRE) begin
          r_sampCnt <= w_preLast ? '0 : (r_sampCnt + CNT_ONE);
        end else if (r_state == ST_POST) begin
          r_sampCnt <= r_sampCnt + CNT_ONE;
        end
      end
    end
  end

  assign overrun   = r_overrun;
  assign trig_addr = r_trigAddr;
  assign wr_req    = r_wrReq;
  assign wr_addr   = r_wrAddr;
  assign wr_data   = r_wrData;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_la_capture_ctrl
// Directed bench for la_capture_ctrl with PROBE_W=8, ADDR_W=8, POS_W=8.
// A memory model records every accepted write; an ack driver models either
// a tied-high ack or an ack delayed by a number of cycles.
// ---------------------------------------------------------------------------
module tb_la_capture_ctrl;

  localparam int PROBE_W = 8;
  localparam int ADDR_W  = 8;
  localparam int DIV_W   = 8;
  localparam int POS_W   = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [PROBE_W-1:0] probe;
  logic [DIV_W-1:0]   divide;
  logic [POS_W-1:0]   pos;
  logic [2:0]         trig_ch;
  logic [1:0]         trig_mode;
  logic               start;
  logic               abort;
  logic               busy;
  logic               done;
  logic               overrun;
  logic [ADDR_W-1:0]  trig_addr;
  logic               wr_req;
  logic [ADDR_W-1:0]  wr_addr;
  logic [PROBE_W-1:0] wr_data;
  logic               wr_ack = 1'b1;

  int checks = 0;
  int errors = 0;

  int writeCount  = 0;
  int captureBase = 0;
  int addrErr     = 0;
  int ackDelay    = 0;
  int reqAge      = 0;
  logic [PROBE_W-1:0] mem [0:255];

  la_capture_ctrl #(
    .PROBE_W(PROBE_W), .ADDR_W(ADDR_W), .DIV_W(DIV_W), .POS_W(POS_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .probe     (probe),
    .divide    (divide),
    .pos       (pos),
    .trig_ch   (trig_ch),
    .trig_mode (trig_mode),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun),
    .trig_addr (trig_addr),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack)
  );

  always #5 clk = ~clk;

  // Memory model: stores accepted writes and checks that the n-th write of
  // the current capture lands at address n mod 256.
  always @(posedge clk) begin
    if (rst_n && wr_req && wr_ack) begin
      if (wr_addr !== 8'(writeCount - captureBase)) addrErr++;
      mem[wr_addr] = wr_data;
      writeCount++;
    end
  end

  // Ack driver: tied high when ackDelay is 0, otherwise ack is raised once
  // wr_req has been high for more than ackDelay cycles.
  always @(negedge clk) begin
    if (wr_req) reqAge++;
    else reqAge = 0;
    if (ackDelay == 0) wr_ack = 1'b1;
    else wr_ack = wr_req && (reqAge > ackDelay);
  end

  task automatic pulseStart;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic setup(input logic [7:0] div, input logic [7:0] p,
                       input logic [2:0] ch, input logic [1:0] mode,
                       input logic [7:0] prb, input int ack);
    divide    = div;
    pos       = p;
    trig_ch   = ch;
    trig_mode = mode;
    probe     = prb;
    ackDelay  = ack;
    captureBase = writeCount;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; probe = '0; divide = '0; pos = '0; trig_ch = '0;
    trig_mode = '0; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, overrun, wr_req} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_status: got %b expected 0000", {busy, done, overrun, wr_req});
    end
    checks++;
    if ({wr_addr, wr_data, trig_addr} !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_regs: got %h expected 000000", {wr_addr, wr_data, trig_addr});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // pos=0xC0, rising on ch3, bit3 rises once 300 writes have been made.
  task automatic test_pretrigger;
    int base, errBase, cnt;
    base = writeCount; errBase = addrErr;
    setup(8'd1, 8'hC0, 3'd3, 2'd0, 8'h00, 0);
    pulseStart();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      cnt = writeCount - base;
      if (cnt >= 300) probe = 8'h08;
      if (done) break;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL pre_done: got %b expected 1", done); end
    checks++;
    if (writeCount - base != 364) begin errors++; $display("[TB] FAIL pre_writes: got %0d expected 364", writeCount - base); end
    checks++;
    if (trig_addr !== 8'd44) begin errors++; $display("[TB] FAIL pre_trig_addr: got %0d expected 44", trig_addr); end
    checks++;
    if (mem[44] !== 8'h08) begin errors++; $display("[TB] FAIL pre_trig_data: got %h expected 08", mem[44]); end
    checks++;
    if (mem[43] !== 8'h00) begin errors++; $display("[TB] FAIL pre_before_trig: got %h expected 00", mem[43]); end
    checks++;
    if (addrErr != errBase) begin errors++; $display("[TB] FAIL pre_addr_seq: got %0d expected %0d", addrErr, errBase); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL pre_busy: got %b expected 0", busy); end
  endtask

  // pos=0, high on ch0 with probe[0]=1: triggers on the first tick.
  task automatic test_pos0_high;
    int base, errBase;
    base = writeCount; errBase = addrErr;
    setup(8'd1, 8'h00, 3'd0, 2'd2, 8'h01, 0);
    pulseStart();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (done) break;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL p0_done: got %b expected 1", done); end
    checks++;
    if (trig_addr !== 8'd0) begin errors++; $display("[TB] FAIL p0_trig_addr: got %0d expected 0", trig_addr); end
    checks++;
    if (writeCount - base != 256) begin errors++; $display("[TB] FAIL p0_writes: got %0d expected 256", writeCount - base); end
    checks++;
    if (mem[0] !== 8'h01) begin errors++; $display("[TB] FAIL p0_first_data: got %h expected 01", mem[0]); end
    checks++;
    if (addrErr != errBase) begin errors++; $display("[TB] FAIL p0_addr_seq: got %0d expected %0d", addrErr, errBase); end
  endtask

  // divide=0 with a 3-cycle ack delay drops ticks; next start clears overrun.
  task automatic test_overrun;
    int base, errBase;
    base = writeCount; errBase = addrErr;
    setup(8'd0, 8'h00, 3'd0, 2'd2, 8'h01, 3);
    pulseStart();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (done) break;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL ovr_done: got %b expected 1", done); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_flag: got %b expected 1", overrun); end
    checks++;
    if (writeCount - base != 256) begin errors++; $display("[TB] FAIL ovr_writes: got %0d expected 256", writeCount - base); end
    checks++;
    if (addrErr != errBase) begin errors++; $display("[TB] FAIL ovr_addr_seq: got %0d expected %0d", addrErr, errBase); end
    setup(8'd1, 8'h00, 3'd0, 2'd2, 8'h01, 0);
    pulseStart();
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clear: got %b expected 0", overrun); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ovr_restart_busy: got %b expected 1", busy); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  // abort and start together mid-ARMED: abort wins, start is dropped.
  task automatic test_abort;
    int base, hold;
    base = writeCount;
    setup(8'd1, 8'hC0, 3'd3, 2'd0, 8'h00, 0);
    pulseStart();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (writeCount - base >= 200) break;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_armed_busy: got %b expected 1", busy); end
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    checks++;
    if ({busy, done, wr_req} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_idle: got %b expected 000", {busy, done, wr_req});
    end
    hold = writeCount;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || writeCount != hold) begin
      errors++;
      $display("[TB] FAIL abort_start_ignored: busy %b writes %0d expected busy 0 writes %0d", busy, writeCount, hold);
    end
  endtask

  // Reset in POST with a write outstanding, then a clean capture.
  task automatic test_reset_mid;
    int base, errBase;
    setup(8'd1, 8'h00, 3'd0, 2'd2, 8'h01, 3);
    base = writeCount;
    pulseStart();
    for (int cyc = 0; cyc < 200; cyc++) begin
      if ((writeCount - base >= 3) && wr_req) break;
      @(negedge clk);
    end
    checks++;
    if ({busy, wr_req} !== 2'b11) begin errors++; $display("[TB] FAIL rstmid_pre: got %b expected 11", {busy, wr_req}); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, overrun, wr_req} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL rstmid_status: got %b expected 0000", {busy, done, overrun, wr_req});
    end
    checks++;
    if ({wr_addr, wr_data, trig_addr} !== 24'h0) begin
      errors++;
      $display("[TB] FAIL rstmid_regs: got %h expected 000000", {wr_addr, wr_data, trig_addr});
    end
    @(negedge clk);
    checks++;
    if (wr_req !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_no_req: got %b expected 0", wr_req); end
    rst_n = 1'b1;
    @(negedge clk);
    base = writeCount; errBase = addrErr;
    setup(8'd1, 8'h00, 3'd0, 2'd2, 8'h01, 0);
    pulseStart();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (done) break;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_recap_status: done %b overrun %b expected done 1 overrun 0", done, overrun);
    end
    checks++;
    if (writeCount - base != 256) begin errors++; $display("[TB] FAIL rstmid_recap_writes: got %0d expected 256", writeCount - base); end
    checks++;
    if (addrErr != errBase) begin errors++; $display("[TB] FAIL rstmid_addr_seq: got %0d expected %0d", addrErr, errBase); end
  endtask

  // Falling on ch7, probe[7] low from start: no first-tick trigger, wraps,
  // then a 1->0 pulse (writes 300..309 high) fires at write 310.
  task automatic test_falling;
    int base, errBase, cnt;
    base = writeCount; errBase = addrErr;
    setup(8'd1, 8'h00, 3'd7, 2'd1, 8'h00, 0);
    pulseStart();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (writeCount - base >= 300) break;
      @(negedge clk);
    end
    checks++;
    if ({busy, done} !== 2'b10) begin errors++; $display("[TB] FAIL fall_no_early_trig: got %b expected 10", {busy, done}); end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      cnt = writeCount - base;
      probe = (cnt >= 300 && cnt < 310) ? 8'h80 : 8'h00;
      if (done) break;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL fall_done: got %b expected 1", done); end
    checks++;
    if (trig_addr !== 8'd54) begin errors++; $display("[TB] FAIL fall_trig_addr: got %0d expected 54", trig_addr); end
    checks++;
    if (writeCount - base != 566) begin errors++; $display("[TB] FAIL fall_writes: got %0d expected 566", writeCount - base); end
    checks++;
    if (addrErr != errBase) begin errors++; $display("[TB] FAIL fall_addr_seq: got %0d expected %0d", addrErr, errBase); end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_pretrigger();
    test_pos0_high();
    test_overrun();
    test_abort();
    test_reset_mid();
    test_falling();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
